// File: rtl/pe_pkg.sv
// Shared widths and signed operand types
// for the weight-stationary PE array.
package pe_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  typedef logic signed [DATA_W-1:0] opnd_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/pe_mac.sv
// Combinational signed multiply-add:
// sum = p + sext(a * w), wrapping at ACC_W.
module pe_mac
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int ACC_W  = pe_pkg::ACC_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [ACC_W-1:0]  p,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;

  assign prod   = a * w;
  assign prod_x = ACC_W'(prod);
  assign sum    = p + prod_x;

endmodule

// File: rtl/pe_cell.sv
// Weight-stationary systolic PE: holds one
// weight, forwards activations east, sums south.
module pe_cell
  import pe_pkg::*;
#(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int ACC_W  = pe_pkg::ACC_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_weight,
  input  logic [DATA_W-1:0] ain,
  input  logic              ain_valid,
  input  logic [DATA_W-1:0] win,
  input  logic [ACC_W-1:0]  pin,
  output logic [DATA_W-1:0] aout,
  output logic              aout_valid,
  output logic [DATA_W-1:0] wout,
  output logic [ACC_W-1:0]  pout,
  output logic              pout_valid
);

  logic signed [DATA_W-1:0] w_q;
  logic signed [ACC_W-1:0]  sum;

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a   (ain),
    .w   (w_q),
    .p   (pin),
    .sum (sum)
  );

  // reset_n is active-high despite its name
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      w_q        <= '0;
      aout       <= '0;
      aout_valid <= 1'b0;
      pout       <= '0;
      pout_valid <= 1'b0;
    end else begin
      if (load_weight)
        w_q <= win;
      aout       <= ain;
      aout_valid <= ain_valid;
      pout       <= ain_valid ? sum : pin;
      pout_valid <= ain_valid;
    end
  end

  assign wout = w_q;

endmodule

// File: tb/tb_pe_cell.sv
// Randomized bench for pe_cell against an
// arithmetic model of the weight-stationary PE.
module tb_pe_cell;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_weight;
  logic [7:0]  ain;
  logic        ain_valid;
  logic [7:0]  win;
  logic [19:0] pin;
  logic [7:0]  aout;
  logic        aout_valid;
  logic [7:0]  wout;
  logic [19:0] pout;
  logic        pout_valid;

  int n_pass = 0;
  int n_total = 0;

  int          m_w;
  logic [7:0]  m_a;
  logic        m_av;
  logic [19:0] m_p;

  pe_cell dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_weight (load_weight),
    .ain         (ain),
    .ain_valid   (ain_valid),
    .win         (win),
    .pin         (pin),
    .aout        (aout),
    .aout_valid  (aout_valid),
    .wout        (wout),
    .pout        (pout),
    .pout_valid  (pout_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [19:0] mac(
    input logic [19:0] p, input int a, input int w);
    longint s;
    s = longint'(p) + longint'(a * w);
    return s[19:0];
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".aout"}, 32'(aout), 32'(m_a));
    chk({tag, ".aval"}, 32'(aout_valid), 32'(m_av));
    chk({tag, ".pout"}, 32'(pout), 32'(m_p));
    chk({tag, ".pval"}, 32'(pout_valid), 32'(m_av));
    chk({tag, ".wout"}, 32'(wout), 32'(m_w[7:0]));
  endtask

  task automatic model_reset();
    m_w = 0; m_a = '0; m_av = 1'b0; m_p = '0;
  endtask

  // Called at a negedge: drive, clock, check.
  task automatic step(input string tag,
                      input logic lw,
                      input logic [7:0] wi,
                      input logic [7:0] a,
                      input logic av,
                      input logic [19:0] p);
    load_weight = lw; win = wi;
    ain = a; ain_valid = av; pin = p;
    @(posedge clk);
    m_p  = av ? mac(p, sx8(a), m_w) : p;
    m_a  = a;
    m_av = av;
    if (lw) m_w = sx8(wi);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    reset_n = 1'b1;
    load_weight = 0; win = 0; ain = 0;
    ain_valid = 0; pin = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all("reset");
    reset_n = 1'b0;

    step("ld5", 1'b1, 8'd5, 8'd0, 1'b0, 20'd0);
    step("hold5", 1'b0, 8'd9, 8'd0, 1'b0, 20'd0);
    chk("wout_is5", 32'(wout), 32'd5);

    step("mac115", 1'b0, 8'd9, 8'd3, 1'b1, 20'd100);
    chk("pout115", 32'(pout), 32'd115);

    step("ldm128", 1'b1, 8'h80, 8'd0, 1'b0, 20'd0);
    step("wrap", 1'b0, 8'd0, 8'h80, 1'b1, 20'h7FFFF);
    chk("pout83fff", 32'(pout), 32'h83FFF);

    step("ld2", 1'b1, 8'd2, 8'd0, 1'b0, 20'd0);
    step("ovl1", 1'b1, 8'd7, 8'd4, 1'b1, 20'd0);
    chk("pout8", 32'(pout), 32'd8);
    step("ovl2", 1'b0, 8'd0, 8'd4, 1'b1, 20'd0);
    chk("pout28", 32'(pout), 32'd28);

    step("byp", 1'b0, 8'd0, 8'h55, 1'b0, 20'd1234);
    chk("pout1234", 32'(pout), 32'd1234);

    for (int i = 0; i < 300; i++) begin
      step("rnd",
           ($urandom_range(0, 3) == 0),
           8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0),
           20'($urandom));
    end

    step("pre_rst", 1'b1, 8'h7F, 8'h81, 1'b1, 20'hABCDE);
    step("pre_rst2", 1'b0, 8'd0, 8'h33, 1'b1, 20'h12345);
    #2;
    reset_n = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b0;
    step("post_rst", 1'b0, 8'd0, 8'h7F, 1'b1, 20'd77);
    chk("pout77", 32'(pout), 32'd77);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end
endmodule

// File: doc/pe_cell.md
PE_CELL -- requirements
Module: pe_cell

Interface
REQ-001 Parameter DATA_W, default 8, bit width of activation and weight operands.
REQ-002 Parameter ACC_W, default 20, bit width of the partial-sum path.
REQ-003 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 Port reset_n, input, 1, asynchronous reset, active-high: asserted when 1 despite the suffix.
REQ-005 Port load_weight, input, 1, weight-load/shift enable.
REQ-006 Port ain, input, DATA_W, signed activation from the west neighbour.
REQ-007 Port ain_valid, input, 1, qualifies ain.
REQ-008 Port win, input, DATA_W, signed weight from the north neighbour.
REQ-009 Port pin, input, ACC_W, signed partial sum from the north neighbour.
REQ-010 Port aout, output, DATA_W, registered activation to the east neighbour.
REQ-011 Port aout_valid, output, 1, registered ain_valid to the east neighbour.
REQ-012 Port wout, output, DATA_W, current weight register to the south neighbour.
REQ-013 Port pout, output, ACC_W, registered partial sum to the south neighbour.
REQ-014 Port pout_valid, output, 1, qualifies pout.

Function
REQ-015 The PE SHALL be a weight-stationary systolic cell holding one signed weight register W.
REQ-016 When load_weight=1 at a rising edge, W SHALL take win; otherwise W SHALL hold.
REQ-017 wout SHALL be a combinational copy of W, so a column of N cells loads N weights in N cycles by shifting.
REQ-018 At every rising edge, aout SHALL take ain and aout_valid SHALL take ain_valid, giving 1-cycle latency.
REQ-019 When ain_valid=1, pout SHALL take pin + sext(ain*W) at the edge, giving 1-cycle latency.
REQ-020 The multiply SHALL use the W value present before that edge, including on an edge where load_weight=1.
REQ-021 The product SHALL be a full 2*DATA_W signed result, sign-extended to ACC_W.
REQ-022 The sum SHALL wrap modulo 2^ACC_W, with no saturation and no overflow flag.
REQ-023 When ain_valid=0, pout SHALL take pin unchanged, as a bypass.
REQ-024 pout_valid SHALL take ain_valid at every rising edge.
REQ-025 Signed extremes SHALL be exact, e.g. -128*-128 = +16384.

Reset
REQ-026 While reset_n=1, W, aout, aout_valid and pout SHALL be 0 immediately (asynchronously), with pout_valid=0 and wout=0.
REQ-027 Deassertion SHALL be synchronized externally; the first active edge after release SHALL behave per REQ-016..024.
REQ-028 Reset asserted mid-stream SHALL discard all in-flight data and the loaded weight.

Structure
REQ-029 A shared package pe_pkg SHALL hold DATA_W, ACC_W and the signed operand/accumulator typedefs used by the array.
REQ-030 One sub-module, pe_mac, SHALL implement the combinational signed multiply plus sign-extend plus add; pe_cell holds all registers.
REQ-031 pe_cell SHALL tile into an array with no glue logic: aout to the east ain, wout to the south win, pout to the south pin.

Verification
REQ-032 Reset: assert reset_n=1 mid-operation -> all outputs 0 within the same cycle, with no clock edge needed.
REQ-033 Weight load: load_weight=1, win=5 for one edge, then load_weight=0 -> wout=5, holding while win changes to 9.
REQ-034 MAC: with W=5, apply ain=3, pin=100, ain_valid=1 -> next edge pout=115, pout_valid=1, aout=3.
REQ-035 Signed/wrap: W=-128, ain=-128, pin=0x7FFFF -> pout = 0x7FFFF+16384 mod 2^20 = 0x83FFF.
REQ-036 Load overlap: W=2, then in the same edge load_weight=1, win=7, ain=4, pin=0 -> pout=8; next edge with ain=4 -> pout=28.
REQ-037 Bypass: ain_valid=0, pin=1234 -> pout=1234, pout_valid=0.
